// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, instruction class masks and NOP encoding
// for the issue stage and its register file.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int PC_W     = 14;
  localparam int REG_IDXW = 6;

  // Instruction class is encoded in ope[1:0].
  localparam logic [1:0] CLASS_JB    = 2'b10;
  localparam logic [1:0] CLASS_FLOAT = 2'b01;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_FADD = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_JR   = 6'b001010;
  localparam logic [5:0] OP_JALR = 6'b001110;
  localparam logic [5:0] OP_BEQ  = 6'b010010;
  localparam logic [5:0] OP_BNE  = 6'b010110;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  function automatic logic is_jump_imm(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic is_jump_reg(input logic [5:0] op);
    return (op == OP_JR) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/reg_file_64x32.sv
// reg_file_64x32: 64 x 32-bit register file with two write ports and two
// write-through bypassed read ports. Index 0 is hardwired to zero.
//   clk, rstn            clock, synchronous active-low reset (clears all entries)
//   wr0_addr / wr0_val   write port 0 (alu), address 0 = no write, has priority
//   wr1_addr / wr1_val   write port 1 (fpu), address 0 = no write
//   rd0_idx / rd0_val    read port 0
//   rd1_idx / rd1_val    read port 1
module reg_file_64x32
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic [REG_IDXW-1:0] wr0_addr,
  input  logic [XLEN-1:0]     wr0_val,
  input  logic [REG_IDXW-1:0] wr1_addr,
  input  logic [XLEN-1:0]     wr1_val,
  input  logic [REG_IDXW-1:0] rd0_idx,
  output logic [XLEN-1:0]     rd0_val,
  input  logic [REG_IDXW-1:0] rd1_idx,
  output logic [XLEN-1:0]     rd1_val
);

  logic [XLEN-1:0] mem [64];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (wr0_addr != '0) mem[wr0_addr] <= wr0_val;
      // Port 0 wins on an address collision, so port 1 is suppressed.
      if (wr1_addr != '0 && wr1_addr != wr0_addr) mem[wr1_addr] <= wr1_val;
    end
  end

  // A nonzero read index matching a write address implies that write is live.
  assign rd0_val = (rd0_idx == '0)       ? '0 :
                   (rd0_idx == wr0_addr) ? wr0_val :
                   (rd0_idx == wr1_addr) ? wr1_val : mem[rd0_idx];

  assign rd1_val = (rd1_idx == '0)       ? '0 :
                   (rd1_idx == wr0_addr) ? wr0_val :
                   (rd1_idx == wr1_addr) ? wr1_val : mem[rd1_idx];

endmodule

// File: rtl/issue_stage.sv
// issue_stage: single-entry instruction register between fetch and execute.
// Decodes fields, reads operands through the bypassed register file, stalls
// on execute-unit busy, and generates jump/branch redirects that squash the
// wrong-path fetch.
//   clk, rstn                         clock, synchronous active-low reset
//   if_valid, if_pc, if_inst, if_ready  fetch handshake
//   redirect_valid, redirect_pc       one-cycle fetch redirect
//   pc, ope, ds_val, dt_val, dd, imm, opr, ctrl  bundle to execute (NOP = all 0)
//   is_busy, b_is_hazard, b_addr      execute feedback
//   alu_addr/alu_dd_val, fpu_addr/fpu_dd_val  writeback ports
//   issued_cnt                        count of non-NOP bundles presented
module issue_stage
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                if_valid,
  input  logic [PC_W-1:0]     if_pc,
  input  logic [XLEN-1:0]     if_inst,
  output logic                if_ready,
  output logic                redirect_valid,
  output logic [PC_W-1:0]     redirect_pc,
  output logic [PC_W-1:0]     pc,
  output logic [5:0]          ope,
  output logic [XLEN-1:0]     ds_val,
  output logic [XLEN-1:0]     dt_val,
  output logic [REG_IDXW-1:0] dd,
  output logic [15:0]         imm,
  output logic [4:0]          opr,
  output logic [3:0]          ctrl,
  input  logic [6:0]          is_busy,
  input  logic                b_is_hazard,
  input  logic [PC_W-1:0]     b_addr,
  input  logic [REG_IDXW-1:0] alu_addr,
  input  logic [XLEN-1:0]     alu_dd_val,
  input  logic [REG_IDXW-1:0] fpu_addr,
  input  logic [XLEN-1:0]     fpu_dd_val,
  output logic [31:0]         issued_cnt
);

  logic                ir_valid;
  logic [PC_W-1:0]     ir_pc;
  logic [XLEN-1:0]     ir_inst;

  logic                stall;
  logic                present;
  logic [5:0]          op;
  logic                cls_jb;
  logic                cls_fl;
  logic [REG_IDXW-1:0] ds_idx;
  logic [REG_IDXW-1:0] dt_idx;
  logic [XLEN-1:0]     ds_raw;
  logic [XLEN-1:0]     dt_raw;
  logic                jmp_imm;
  logic                jmp_reg;
  logic                is_branch;

  assign stall    = ir_valid && (is_busy != '0);
  assign present  = ir_valid && !stall;
  assign if_ready = !stall || !ir_valid;

  assign op     = ir_inst[31:26];
  assign cls_jb = (op[1:0] == CLASS_JB);
  assign cls_fl = (op[1:0] == CLASS_FLOAT);

  assign ds_idx = cls_jb ? {1'b0, ir_inst[25:21]} : {cls_fl, ir_inst[20:16]};
  assign dt_idx = cls_jb ? {1'b0, ir_inst[20:16]} : {cls_fl, ir_inst[15:11]};

  assign jmp_imm   = is_jump_imm(op);
  assign jmp_reg   = is_jump_reg(op);
  assign is_branch = cls_jb && !jmp_imm && !jmp_reg;

  reg_file_64x32 u_rf (
    .clk      (clk),
    .rstn     (rstn),
    .wr0_addr (alu_addr),
    .wr0_val  (alu_dd_val),
    .wr1_addr (fpu_addr),
    .wr1_val  (fpu_dd_val),
    .rd0_idx  (ds_idx),
    .rd0_val  (ds_raw),
    .rd1_idx  (dt_idx),
    .rd1_val  (dt_raw)
  );

  always_comb begin
    pc             = '0;
    ope            = OP_NOP;
    ds_val         = '0;
    dt_val         = '0;
    dd             = '0;
    imm            = '0;
    opr            = '0;
    ctrl           = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (present) begin
      pc     = ir_pc;
      ope    = op;
      ds_val = ds_raw;
      dt_val = dt_raw;
      dd     = cls_jb ? '0 : {cls_fl, ir_inst[25:21]};
      imm    = ir_inst[15:0];
      opr    = cls_jb ? ir_inst[20:16] : '0;
      ctrl   = ir_inst[10:7];
      if (jmp_imm) begin
        redirect_valid = 1'b1;
        redirect_pc    = ir_inst[13:0];
      end else if (jmp_reg) begin
        redirect_valid = 1'b1;
        redirect_pc    = ds_raw[13:0];
      end else if (is_branch && b_is_hazard) begin
        redirect_valid = 1'b1;
        redirect_pc    = b_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ir_valid   <= 1'b0;
      ir_pc      <= '0;
      ir_inst    <= NOP_INST;
      issued_cnt <= '0;
    end else begin
      if (present) issued_cnt <= issued_cnt + 32'd1;
      // Redirect squashes whatever fetch is offering this cycle.
      if (redirect_valid) begin
        ir_valid <= 1'b0;
      end else if (if_valid && if_ready) begin
        ir_valid <= 1'b1;
        ir_pc    <= if_pc;
        ir_inst  <= if_inst;
      end else if (present) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
module tb_issue_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_valid;
  logic [13:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        redirect_valid;
  logic [13:0] redirect_pc;
  logic [13:0] pc;
  logic [5:0]  ope;
  logic [31:0] ds_val, dt_val;
  logic [5:0]  dd;
  logic [15:0] imm;
  logic [4:0]  opr;
  logic [3:0]  ctrl;
  logic [6:0]  is_busy;
  logic        b_is_hazard;
  logic [13:0] b_addr;
  logic [5:0]  alu_addr, fpu_addr;
  logic [31:0] alu_dd_val, fpu_dd_val;
  logic [31:0] issued_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  issue_stage dut (
    .clk(clk), .rstn(rstn),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .ope(ope), .ds_val(ds_val), .dt_val(dt_val), .dd(dd),
    .imm(imm), .opr(opr), .ctrl(ctrl),
    .is_busy(is_busy), .b_is_hazard(b_is_hazard), .b_addr(b_addr),
    .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
    .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
    .issued_cnt(issued_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge and
  // outputs are checked a further 1ns later, both well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_ope"}, {26'd0, ope}, 32'd0);
    chk({tag, "_ds"}, ds_val, 32'd0);
    chk({tag, "_pc"}, {18'd0, pc}, 32'd0);
    chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    is_busy = '0; b_is_hazard = 1'b0; b_addr = '0;
    alu_addr = '0; alu_dd_val = '0; fpu_addr = '0; fpu_dd_val = '0;
    step(); step();
    settle();
    chk_nop("rst");
    chk("rst_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_cnt", issued_cnt, 32'd0);

    // ADDI r1,r0,5 at pc 10
    rstn = 1'b1; if_valid = 1'b1; if_pc = 14'd10;
    if_inst = {OP_ADDI, 5'd1, 5'd0, 16'd5};
    step();
    // ADD r2,r1,r1 with ctrl=5 at pc 11
    if_pc = 14'd11; if_inst = {OP_ADD, 5'd2, 5'd1, 5'd1, 11'h280};
    settle();
    chk("addi_ope", {26'd0, ope}, {26'd0, OP_ADDI});
    chk("addi_dd", {26'd0, dd}, 32'd1);
    chk("addi_imm", {16'd0, imm}, 32'd5);
    chk("addi_pc", {18'd0, pc}, 32'd10);
    chk("addi_ready", {31'd0, if_ready}, 32'd1);
    step();
    // ALU returns ADDI result while ADD is presented
    alu_addr = 6'd1; alu_dd_val = 32'd5;
    if_pc = 14'd12; if_inst = {OP_ADD, 5'd4, 5'd1, 5'd0, 11'd0};
    settle();
    chk("byp_ds", ds_val, 32'd5);
    chk("byp_dt", dt_val, 32'd5);
    chk("add_dd", {26'd0, dd}, 32'd2);
    chk("add_ctrl", {28'd0, ctrl}, 32'd5);
    chk("add_cnt", issued_cnt, 32'd1);
    step();
    // ADD r4 loaded; stall 3 cycles
    alu_addr = '0; alu_dd_val = '0; is_busy = 7'b0000001;
    if_pc = 14'd13; if_inst = {OP_JAL, 12'd0, 14'h0123};
    for (int c = 0; c < 3; c++) begin
      settle();
      chk_nop("stall");
      chk("stall_ready", {31'd0, if_ready}, 32'd0);
      step();
    end
    is_busy = '0;
    settle();
    chk("unstall_pc", {18'd0, pc}, 32'd12);
    chk("unstall_ope", {26'd0, ope}, {26'd0, OP_ADD});
    chk("unstall_ds", ds_val, 32'd5);
    chk("unstall_cnt", issued_cnt, 32'd2);
    step();
    // JAL presented; wrong-path fetch offered
    if_pc = 14'd14; if_inst = {OP_ADD, 5'd7, 5'd1, 5'd1, 11'd0};
    settle();
    chk("jal_rv", {31'd0, redirect_valid}, 32'd1);
    chk("jal_rpc", {18'd0, redirect_pc}, 32'h0123);
    chk("jal_dd", {26'd0, dd}, 32'd0);
    step();
    // squashed; JR r3 offered
    if_pc = 14'd20; if_inst = {OP_JR, 5'd3, 21'd0};
    settle();
    chk_nop("squash");
    chk("squash_ready", {31'd0, if_ready}, 32'd1);
    chk("squash_cnt", issued_cnt, 32'd4);
    step();
    alu_addr = 6'd3; alu_dd_val = 32'h2A;
    if_pc = 14'd21; if_inst = {OP_FADD, 5'd2, 5'd1, 5'd1, 11'd0};
    settle();
    chk("jr_rv", {31'd0, redirect_valid}, 32'd1);
    chk("jr_rpc", {18'd0, redirect_pc}, 32'h002A);
    chk("jr_ds", ds_val, 32'h2A);
    step();
    alu_addr = '0; alu_dd_val = '0;
    settle();
    chk_nop("jr_squash");
    step();
    // FADD reading f33 with both ports writing 33
    alu_addr = 6'd33; alu_dd_val = 32'd1; fpu_addr = 6'd33; fpu_dd_val = 32'd2;
    if_pc = 14'd22; if_inst = {OP_FADD, 5'd3, 5'd1, 5'd1, 11'd0};
    settle();
    chk("fadd_dd", {26'd0, dd}, 32'd34);
    chk("coll_ds", ds_val, 32'd1);
    chk("coll_dt", dt_val, 32'd1);
    chk("fadd_cnt", issued_cnt, 32'd5);
    step();
    alu_addr = '0; alu_dd_val = '0; fpu_addr = '0; fpu_dd_val = '0;
    if_pc = 14'd23; if_inst = {OP_ADD, 5'd5, 5'd0, 5'd0, 11'd0};
    settle();
    chk("r33_stored", ds_val, 32'd1);
    step();
    alu_addr = '0; alu_dd_val = 32'hDEAD; fpu_addr = '0; fpu_dd_val = 32'hBEEF;
    if_pc = 14'd24; if_inst = {OP_BEQ, 5'd1, 5'd7, 16'h0010};
    settle();
    chk("r0_ds", ds_val, 32'd0);
    chk("r0_dt", dt_val, 32'd0);
    step();
    alu_dd_val = '0; fpu_dd_val = '0;
    if_pc = 14'd25; if_inst = {OP_BNE, 5'd1, 5'd7, 16'h0020};
    settle();
    chk("beq_nt_rv", {31'd0, redirect_valid}, 32'd0);
    chk("beq_opr", {27'd0, opr}, 32'd7);
    chk("beq_ds", ds_val, 32'd5);
    chk("beq_cnt", issued_cnt, 32'd8);
    step();
    b_is_hazard = 1'b1; b_addr = 14'h0055;
    if_pc = 14'd26; if_inst = {OP_ADD, 5'd6, 5'd1, 5'd0, 11'd0};
    settle();
    chk("bne_t_rv", {31'd0, redirect_valid}, 32'd1);
    chk("bne_t_rpc", {18'd0, redirect_pc}, 32'h0055);
    step();
    b_is_hazard = 1'b0; b_addr = '0;
    settle();
    chk_nop("br_squash");
    step();
    // ADD r6 loaded; stall then reset
    is_busy = 7'b0000001;
    settle();
    chk_nop("pre_rst_stall");
    chk("pre_rst_cnt", issued_cnt, 32'd10);
    rstn = 1'b0;
    step();
    settle();
    chk_nop("rst_stall");
    chk("rst_stall_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_stall_cnt", issued_cnt, 32'd0);
    rstn = 1'b1; is_busy = '0;
    if_pc = 14'd30; if_inst = {OP_ADD, 5'd6, 5'd1, 5'd1, 11'd0};
    step();
    settle();
    chk("post_rst_pc", {18'd0, pc}, 32'd30);
    chk("post_rst_r1", ds_val, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: rstn  input  1  reset, synchronous, active-low.
REQ-003 SHALL: if_valid  input  1  fetch presents an instruction.
REQ-004 SHALL: if_pc  input  14  word PC of presented instruction.
REQ-005 SHALL: if_inst  input  32  presented instruction word.
REQ-006 SHALL: if_ready  output  1  issue stage accepts if_inst this cycle.
REQ-007 SHALL: redirect_valid / redirect_pc  output  1 / 14  one-cycle fetch redirect and target.
REQ-008 SHALL: pc, ope, ds_val, dt_val, dd, imm, opr, ctrl  output  14, 6, 32, 32, 6, 16, 5, 4  operand bundle to the execute unit.
REQ-009 SHALL: is_busy  input  7  execute-unit busy bits; b_is_hazard  input  1  branch taken; b_addr  input  14  branch target.
REQ-010 SHALL: alu_addr/alu_dd_val, fpu_addr/fpu_dd_val  input  6/32 each  writeback ports; address 0 = no write.

Function
REQ-011 SHALL: hold one instruction register (ir_valid, ir_pc, ir_inst); load from if_* when if_valid && if_ready.
REQ-012 SHALL: if_ready = ~stall || ~ir_valid, where stall = ir_valid && (is_busy != 0).
REQ-013 SHALL: field decode: ope=inst[31:26], imm=inst[15:0], ctrl=inst[10:7].
REQ-014 SHALL: class J/B (ope[1:0]==10): ds idx=inst[25:21], dt idx=inst[20:16], opr=inst[20:16], dd=0.
REQ-015 SHALL: other classes: dd=inst[25:21], ds idx=inst[20:16], dt idx=inst[15:11], opr=0.
REQ-016 SHALL: float class (ope[1:0]==01): bit 5 of dd, ds idx, dt idx = 1; otherwise 0.
REQ-017 SHALL: 64x32 register file, written each cycle from alu port and fpu port; same address on both: alu wins.
REQ-018 SHALL: index 0 always reads 0; writes to index 0 ignored.
REQ-019 SHALL: reads write-through bypassed: alu port match first, then fpu port, then array; zero issue-to-issue latency for dependent ALU ops.
REQ-020 SHALL: when ~ir_valid or stall, present NOP: ope=000000, dd=0, all other bundle outputs 0; ir held during stall.
REQ-021 SHALL: when presented non-NOP: pc=ir_pc; ds_val/dt_val = bypassed reads.
REQ-022 SHALL: jumps 000010/000110 redirect to inst[13:0]; 001010/001110 redirect to bypassed ds_val[13:0].
REQ-023 SHALL: branch: b_is_hazard=1 while a branch is presented -> redirect to b_addr.
REQ-024 SHALL: on redirect: redirect_valid=1 same cycle (combinational), next ir_valid=0 regardless of if_valid (squash wrong-path).
REQ-025 SHALL: redirect never asserted while stalled or ~ir_valid.
REQ-026 SHALL: 32-bit issued_cnt increments per non-NOP presented, wraps FFFFFFFF->0.

Reset
REQ-027 SHALL: on ~rstn at clk edge: ir_valid=0, ir_pc=0, ir_inst=0, issued_cnt=0, all 64 registers=0.
REQ-028 SHALL: reset mid-stall or mid-redirect discards ir; first cycle after reset presents NOP, if_ready=1.

Structure
REQ-029 SHALL: opcode constants, class masks (J/B 10, float 01), NOP value in shared package cpu_pkg.
REQ-030 SHALL: register file + bypass as sub-module reg_file_64x32 (2 read, 2 write ports).

Verification
REQ-031 SHALL: ADDI r1,r0,5 then ADD r2,r1,r1 back-to-back -> second presents ds_val=dt_val=5 (bypass).
REQ-032 SHALL: is_busy=0000001 for 3 cycles with valid ir -> NOP 3 cycles, if_ready=0, ir unchanged, issues on cycle 4.
REQ-033 SHALL: JAL target 0x0123 -> redirect_valid=1, redirect_pc=0x0123, next fetched instruction squashed (ir_valid=0).
REQ-034 SHALL: JR r3 with r3 written 0x2A by alu port same cycle -> redirect_pc=0x002A.
REQ-035 SHALL: alu_addr=fpu_addr=33, values 1/2 -> register 33 reads 1; write to addr 0 -> reads 0.
REQ-036 SHALL: rstn low during stall -> next cycle NOP, if_ready=1, issued_cnt=0.
